ex_muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage. It owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ID/EX stage register.
- Runs 32-iteration shift-add multiply or restoring divide.
- Asserts Stall back to the hazard logic while a later instruction needs HI/LO or the unit.
- Feeds HI/LO to the EX result mux (MFHI/MFLO).

---
 rtl/cpu_pkg.sv | 19 +
 rtl/muldiv_sign_fix.sv | 29 ++
 rtl/ex_muldiv_unit.sv | 215 +++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared op encodings, FSM states and default width for the EX muldiv unit
package cpu_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - two's complement sign correction of a HI/LO pair
// Wide mode negates {hi,lo} as one value under neg_lo_i; otherwise each half is negated on its own flag.
module muldiv_sign_fix
    import cpu_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             neg_hi_i,
    input  logic             neg_lo_i,
    input  logic             wide_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] wide_neg;

    always_comb begin
        wide_neg = -{hi_i, lo_i};
        if (wide_i) begin
            {hi_o, lo_o} = neg_lo_i ? wide_neg : {hi_i, lo_i};
        end else begin
            hi_o = neg_hi_i ? -hi_i : hi_i;
            lo_o = neg_lo_i ? -lo_i : lo_i;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - multi-cycle MULT/DIV unit owning HI/LO; MULDIV_EARLY_TERM_EN enables multiply early termination
// FIX performs the final iteration together with sign correction and the HI/LO write.
module ex_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiLoRead,
    input  logic             Flush,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    muldiv_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_a_q, neg_a_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;
    logic               divzero_q, divzero_d;

    logic               op_signed, op_div;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     rtmp;
    logic [WIDTH-1:0]   rdiff;
    logic               rge;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] fin;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign op_signed = (Op == OP_MULT) || (Op == OP_DIV);
    assign op_div    = (Op == OP_DIV) || (Op == OP_DIVU);

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs (
        .hi_i     (A),
        .lo_i     (B),
        .neg_hi_i (op_signed & A[WIDTH-1]),
        .neg_lo_i (op_signed & B[WIDTH-1]),
        .wide_i   (1'b0),
        .hi_o     (a_abs),
        .lo_o     (b_abs)
    );

    // Multiply: add multiplicand on LSB, shift right. Divide: shift left, trial-subtract.
    assign msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign rtmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rge   = rtmp >= {1'b0, b_q};
    assign rdiff = rtmp[WIDTH-1:0] - b_q;
    assign step  = is_div_q ? {(rge ? rdiff : rtmp[WIDTH-1:0]), acc_q[WIDTH-2:0], rge}
                            : {msum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_EARLY_TERM_EN
    logic [CNT_W-1:0] fin_sh;
    assign fin_sh = CNT_W'(WIDTH-1) - cnt_q;
    assign fin    = is_div_q ? step : (step >> fin_sh);
`else
    assign fin    = step;
`endif

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .hi_i     (fin[2*WIDTH-1:WIDTH]),
        .lo_i     (fin[WIDTH-1:0]),
        .neg_hi_i (is_div_q & neg_a_q),
        .neg_lo_i (neg_q),
        .wide_i   (~is_div_q),
        .hi_o     (fix_hi),
        .lo_o     (fix_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_a_d   = neg_a_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;
        case (state_q)
            ST_IDLE: begin
                if (Start && !Flush) begin
                    case (Op)
                        OP_MTHI: begin
                            hi_d      = A;
                            divzero_d = 1'b0;
                        end
                        OP_MTLO: begin
                            lo_d      = A;
                            divzero_d = 1'b0;
                        end
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            divzero_d = 1'b0;
                            dz_d      = op_div && (B == '0);
                            // Divide by zero returns the raw dividend in HI.
                            a_d       = (op_div && (B == '0)) ? A : a_abs;
                            b_d       = b_abs;
                            acc_d     = {{WIDTH{1'b0}}, (op_div ? a_abs : b_abs)};
                            is_div_d  = op_div;
                            neg_d     = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_a_d   = op_signed & A[WIDTH-1];
                            cnt_d     = '0;
                            state_d   = ST_RUN;
                            if (op_div && (B == '0)) begin
                                state_d = ST_FIX;
                            end
`ifdef MULDIV_EARLY_TERM_EN
                            if (!op_div && (b_abs[WIDTH-1:1] == '0)) begin
                                state_d = ST_FIX;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + 1'b1;
                    if (!is_div_q) begin
                        b_d = b_q >> 1;
                    end
                    if (cnt_q == CNT_W'(WIDTH-2)) begin
                        state_d = ST_FIX;
                    end
`ifdef MULDIV_EARLY_TERM_EN
                    else if (!is_div_q && (b_q[WIDTH-1:2] == '0)) begin
                        state_d = ST_FIX;
                    end
`endif
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!Flush) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        lo_d      = '1;
                        hi_d      = a_q;
                        divzero_d = 1'b1;
                    end else begin
                        hi_d = fix_hi;
                        lo_d = fix_lo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_a_q   <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_a_q   <= neg_a_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign Busy    = (state_q != ST_IDLE);
    assign Stall   = Busy & (Start | HiLoRead);
    assign Done    = done_q;
    assign DivZero = divzero_q;
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
    import cpu_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Rst, Start, HiLoRead, Flush;
    logic [2:0]   Op;
    logic [W-1:0] A, B;
    logic         Busy, Stall, Done, DivZero;
    logic [W-1:0] HI, LO;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiLoRead(HiLoRead), .Flush(Flush), .Busy(Busy), .Stall(Stall),
        .Done(Done), .DivZero(DivZero), .HI(HI), .LO(LO)
    );

    function automatic int exp_mul_lat(input logic [W-1:0] bmag);
        int idx;
        idx = 0;
        for (int i = 0; i < W; i++) if (bmag[i]) idx = i;
        return EARLY ? 2 + idx : W + 1;
    endfunction

    // Issues one op and waits (bounded) for Done; lat counts the start edge too.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cycles);
        int n;
        bit seen;
        @(negedge Clk); Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk); Start = 1'b0;
        n = 0; seen = 1'b0; busy_cycles = 0;
        busy_cycles += int'(Busy);
        if (Done) seen = 1'b1;
        while (!seen && n < 100) begin
            @(negedge Clk); n++;
            busy_cycles += int'(Busy);
            if (Done) seen = 1'b1;
        end
        lat = n + 1;
        checks++;
        if (!seen) begin errors++; $display("FAIL done_timeout: op %0d no Done within %0d cycles", op, n); end
    endtask

    task automatic test_reset();
        Rst = 1'b0; Start = 1'b0; Op = 3'd7; A = '0; B = '0; HiLoRead = 1'b0; Flush = 1'b0;
        repeat (3) @(negedge Clk);
        checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b expected 0", Busy); end
        checks++; if (Done !== 1'b0)    begin errors++; $display("FAIL rst_done: got %b expected 0", Done); end
        checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL rst_divzero: got %b expected 0", DivZero); end
        checks++; if (HI !== 32'h0)     begin errors++; $display("FAIL rst_hi: got %h expected 0", HI); end
        checks++; if (LO !== 32'h0)     begin errors++; $display("FAIL rst_lo: got %h expected 0", LO); end
        checks++; if (Stall !== 1'b0)   begin errors++; $display("FAIL rst_stall: got %b expected 0", Stall); end
        Rst = 1'b1;
    endtask

    task automatic test_mult();
        int lat, bc;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bc);
        checks++; if (lat !== exp_mul_lat(32'd7))     begin errors++; $display("FAIL mult_lat: got %0d expected %0d", lat, exp_mul_lat(32'd7)); end
        checks++; if (bc !== exp_mul_lat(32'd7) - 1)  begin errors++; $display("FAIL mult_busy_cycles: got %0d expected %0d", bc, exp_mul_lat(32'd7) - 1); end
        checks++; if (HI !== 32'hFFFF_FFFF)           begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", HI); end
        checks++; if (LO !== 32'hFFFF_FFEB)           begin errors++; $display("FAIL mult_lo: got %h expected ffffffeb", LO); end
        @(negedge Clk);
        checks++; if (Done !== 1'b0)                  begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", Done); end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        checks++; if (lat !== W + 1)                  begin errors++; $display("FAIL multu_lat: got %0d expected %0d", lat, W + 1); end
        checks++; if ({HI, LO} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max: got %h%h expected fffffffe00000001", HI, LO); end
        run_op(OP_MULT, 32'h0000_1234, 32'd0, lat, bc);
        checks++; if (lat !== exp_mul_lat(32'd0))     begin errors++; $display("FAIL mult_zero_lat: got %0d expected %0d", lat, exp_mul_lat(32'd0)); end
        checks++; if ({HI, LO} !== 64'h0)             begin errors++; $display("FAIL mult_zero: got %h%h expected 0", HI, LO); end
    endtask

    task automatic test_div();
        int lat, bc;
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bc);
        checks++; if (lat !== W + 1)        begin errors++; $display("FAIL divu_lat: got %0d expected %0d", lat, W + 1); end
        checks++; if (LO !== 32'd14)        begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", LO); end
        checks++; if (HI !== 32'd2)         begin errors++; $display("FAIL divu_hi: got %h expected 00000002", HI); end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc);
        checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected fffffffd", LO); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected ffffffff", HI); end
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, bc);
        checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb_lo: got %h expected fffffffd", LO); end
        checks++; if (HI !== 32'd1)         begin errors++; $display("FAIL div_negb_hi: got %h expected 00000001", HI); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", LO); end
        checks++; if (HI !== 32'h0)         begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", HI); end
        checks++; if (DivZero !== 1'b0)     begin errors++; $display("FAIL div_ovf_flag: got %b expected 0", DivZero); end
    endtask

    task automatic test_divzero();
        int lat, bc;
        run_op(OP_DIV, 32'd5, 32'd0, lat, bc);
        checks++; if (lat !== 2)            begin errors++; $display("FAIL dz_lat: got %0d expected 2", lat); end
        checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo: got %h expected ffffffff", LO); end
        checks++; if (HI !== 32'd5)         begin errors++; $display("FAIL dz_hi: got %h expected 00000005", HI); end
        checks++; if (DivZero !== 1'b1)     begin errors++; $display("FAIL dz_flag: got %b expected 1", DivZero); end
        @(negedge Clk); Start = 1'b1; Op = 3'd7; A = 32'd77;
        @(negedge Clk); Start = 1'b0;
        checks++; if (DivZero !== 1'b1)     begin errors++; $display("FAIL dz_nop_keeps: got %b expected 1", DivZero); end
        checks++; if (HI !== 32'd5)         begin errors++; $display("FAIL nop_hi: got %h expected 00000005", HI); end
        Start = 1'b1; Op = OP_MTLO; A = 32'd9;
        @(negedge Clk); Start = 1'b0;
        checks++; if (LO !== 32'd9)         begin errors++; $display("FAIL mtlo_lo: got %h expected 00000009", LO); end
        checks++; if (DivZero !== 1'b0)     begin errors++; $display("FAIL mtlo_clears_dz: got %b expected 0", DivZero); end
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL mtlo_single_cycle: busy %b done %b expected 0 0", Busy, Done); end
    endtask

    task automatic test_back_to_back();
        int n, stall_cycles, stall_bad;
        @(negedge Clk); Start = 1'b1; Op = OP_MULTU; A = 32'd6; B = 32'h8000_0001;
        @(negedge Clk); Start = 1'b0;
        repeat (4) @(negedge Clk);
        Start = 1'b1; Op = OP_MULT; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; HiLoRead = 1'b1;
        n = 0; stall_cycles = 0; stall_bad = 0;
        while (n < 100) begin
            @(negedge Clk); n++;
            if (!Busy) break;
            stall_cycles++;
            if (Stall !== 1'b1) stall_bad++;
        end
        checks++; if (Stall !== 1'b0)     begin errors++; $display("FAIL b2b_stall_release: got %b expected 0", Stall); end
        Start = 1'b0; HiLoRead = 1'b0;
        checks++; if (stall_bad !== 0)    begin errors++; $display("FAIL b2b_stall_low: got %0d low cycles expected 0", stall_bad); end
        checks++; if (stall_cycles !== 27) begin errors++; $display("FAIL b2b_stall_cycles: got %0d expected 27", stall_cycles); end
        checks++; if (Done !== 1'b1)      begin errors++; $display("FAIL b2b_done: got %b expected 1", Done); end
        @(negedge Clk);
        checks++; if (Busy !== 1'b0)      begin errors++; $display("FAIL b2b_second_ignored: busy %b expected 0", Busy); end
        checks++; if ({HI, LO} !== 64'h0000_0003_0000_0006) begin errors++; $display("FAIL b2b_result: got %h%h expected 0000000300000006", HI, LO); end
    endtask

    task automatic preload();
        @(negedge Clk); Start = 1'b1; Op = OP_MTHI; A = 32'h1111_1111;
        @(negedge Clk); Op = OP_MTLO; A = 32'h2222_2222;
        @(negedge Clk); Start = 1'b0;
    endtask

    task automatic test_abort();
        int dcnt;
        preload();
        checks++; if ({HI, LO} !== 64'h1111_1111_2222_2222) begin errors++; $display("FAIL preload: got %h%h expected 1111111122222222", HI, LO); end
        @(negedge Clk); Start = 1'b1; Op = OP_DIVU; A = 32'd1000; B = 32'd3;
        @(negedge Clk); Start = 1'b0;
        repeat (9) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk); Rst = 1'b1;
        checks++; if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL rst_mid_hilo: got %h%h expected 0", HI, LO); end
        checks++; if (Busy !== 1'b0)      begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", Busy); end
        dcnt = 0;
        repeat (40) begin @(negedge Clk); dcnt += int'(Done); end
        checks++; if (dcnt !== 0)         begin errors++; $display("FAIL rst_mid_done: got %0d pulses expected 0", dcnt); end
        preload();
        @(negedge Clk); Start = 1'b1; Op = OP_DIVU; A = 32'd1000; B = 32'd3;
        @(negedge Clk); Start = 1'b0;
        repeat (9) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk); Flush = 1'b0;
        checks++; if (Busy !== 1'b0)      begin errors++; $display("FAIL flush_busy: got %b expected 0", Busy); end
        dcnt = 0;
        repeat (40) begin @(negedge Clk); dcnt += int'(Done); end
        checks++; if (dcnt !== 0)         begin errors++; $display("FAIL flush_done: got %0d pulses expected 0", dcnt); end
        checks++; if ({HI, LO} !== 64'h1111_1111_2222_2222) begin errors++; $display("FAIL flush_hilo: got %h%h expected 1111111122222222", HI, LO); end
        @(negedge Clk); Start = 1'b1; Flush = 1'b1; Op = OP_MTHI; A = 32'hDEAD_BEEF;
        @(negedge Clk); Op = OP_MULT;
        @(negedge Clk); Start = 1'b0; Flush = 1'b0;
        checks++; if (HI !== 32'h1111_1111) begin errors++; $display("FAIL flush_idle_mthi: got %h expected 11111111", HI); end
        checks++; if (Busy !== 1'b0)        begin errors++; $display("FAIL flush_idle_mult: busy %b expected 0", Busy); end
    endtask

    task automatic test_early_term();
        int lat, bc;
        run_op(OP_MULTU, 32'h1234_5678, 32'd3, lat, bc);
        checks++; if (lat !== (EARLY ? 3 : W + 1)) begin errors++; $display("FAIL early_lat: got %0d expected %0d", lat, EARLY ? 3 : W + 1); end
        checks++; if (LO !== 32'h369D_0368)        begin errors++; $display("FAIL early_lo: got %h expected 369d0368", LO); end
        checks++; if (HI !== 32'h0)                begin errors++; $display("FAIL early_hi: got %h expected 00000000", HI); end
        run_op(OP_DIVU, 32'd100, 32'd3, lat, bc);
        checks++; if (lat !== W + 1)               begin errors++; $display("FAIL early_div_lat: got %0d expected %0d", lat, W + 1); end
        checks++; if ({HI, LO} !== {32'd1, 32'd33}) begin errors++; $display("FAIL early_div_res: got %h%h expected 0000000100000021", HI, LO); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_divzero();
        test_back_to_back();
        test_abort();
        test_early_term();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
